// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the host-link serializer: FSM encoding, byte order
// and default widths (the deserializer uses the same byte-order constant).
package parallel_to_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Host link carries every word most-significant byte first.
  localparam bit MSB_FIRST = 1'b1;

  localparam int DEFAULT_DBITS = 32;
  localparam int DEFAULT_ABITS = 8;
  localparam int DEFAULT_CBITS = 8;

endpackage

// File: rtl/parallel_to_serial_if.sv
// Command, RAM read port and UART TX byte handshake of the serializer.
// master = serializer side, slave = host / RAM / UART side.
interface parallel_to_serial_if
  import parallel_to_serial_pkg::*;
#(
  parameter int DBITS = DEFAULT_DBITS,
  parameter int ABITS = DEFAULT_ABITS,
  parameter int CBITS = DEFAULT_CBITS
);
  logic             start;
  logic [ABITS-1:0] start_addr;
  logic [CBITS-1:0] word_count;
  logic             rd_en;
  logic [ABITS-1:0] rd_addr;
  logic [DBITS-1:0] rd_data;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;

  modport master (
    input  start, start_addr, word_count, rd_data, tx_ready,
    output rd_en, rd_addr, tx_byte, tx_valid, busy, done
  );

  modport slave (
    output start, start_addr, word_count, rd_data, tx_ready,
    input  rd_en, rd_addr, tx_byte, tx_valid, busy, done
  );
endinterface

// File: rtl/parallel_to_serial_byte_shifter.sv
// Word-to-byte shift register: loads one RAM word, presents the leading byte
// and advances one byte per accepted handshake; last flags the final byte.
module byte_shifter
  import parallel_to_serial_pkg::*;
#(
  parameter int DBITS = DEFAULT_DBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [DBITS-1:0] din,
  output logic [7:0]       tx_byte,
  output logic             last
);
  localparam int BYTES = DBITS / 8;
  localparam int CW    = $clog2(BYTES);

  logic [DBITS-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= din;
      cnt_q  <= CW'(BYTES - 1);
    end else if (shift) begin
      sreg_q <= MSB_FIRST ? (sreg_q << 8) : (sreg_q >> 8);
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign tx_byte = MSB_FIRST ? sreg_q[DBITS-1 -: 8] : sreg_q[7:0];
  assign last    = (cnt_q == '0);

endmodule

// File: rtl/parallel_to_serial.sv
// Reads a run of RAM words on a start command and streams them MSB-first as
// bytes over a valid/ready handshake to the UART transmitter, then pulses done.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int DBITS = DEFAULT_DBITS,
  parameter int ABITS = DEFAULT_ABITS,
  parameter int CBITS = DEFAULT_CBITS
) (
  input logic                  clk,
  input logic                  rst,
  parallel_to_serial_if.master bus
);
  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [CBITS-1:0] words_q, words_d;
  logic             rd_en_q, tx_valid_q, busy_q, done_q;
  logic             done_d;
  logic             load, hs, last;
  logic [7:0]       tx_byte;

  assign hs = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          words_d = bus.word_count;
          if (bus.word_count == '0) done_d  = 1'b1;
          else                      state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        load    = 1'b1;
        addr_d  = addr_q + 1'b1;
        words_d = words_q - 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (hs && last) begin
          if (words_q != '0) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one leaves a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      rd_en_q    <= (state_d == ST_READ);
      tx_valid_q <= (state_d == ST_SHIFT);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
    end
  end

  byte_shifter #(.DBITS(DBITS)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (hs),
    .din     (bus.rd_data),
    .tx_byte (tx_byte),
    .last    (last)
  );

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = addr_q;
  assign bus.tx_byte  = tx_byte;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart of the host-link byte deserializer. On a start command it reads a run of DBITS-wide result words (e.g. the exponentiation result) from the operand RAM. It serializes each word MSB-first into bytes and hands them to the UART transmitter over a valid/ready byte handshake, then pulses `done`. It sits between the RSA datapath's RAM read port and the UART TX.

## Interface
- `DBITS`, 32: RAM word width; a multiple of 8, at least 16; BYTES = DBITS/8
- `ABITS`, 8: RAM address width
- `CBITS`, 8: word-count width
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle command pulse; sampled only in IDLE
- `start_addr`  in  ABITS  address of first word; captured with `start`
- `word_count`  in  CBITS  number of words to send; captured with `start`
- `rd_en`  out  1  RAM read strobe
- `rd_addr`  out  ABITS  RAM read address
- `rd_data`  in  DBITS  RAM read data, valid exactly 1 cycle after `rd_en`
- `tx_byte`  out  8  byte to UART TX
- `tx_valid`  out  1  `tx_byte` is valid
- `tx_ready`  in  1  UART TX accepts the byte; transfer occurs when `tx_valid && tx_ready`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of command

## Operation
- States: IDLE, READ, WAIT, SHIFT.
- **IDLE**
  - On `start`: latch `start_addr` into addr register and `word_count` into words-left register.
  - If `word_count` == 0: assert `done` next cycle and stay in IDLE; no reads are issued.
  - Otherwise: go to READ.
- **READ**
  - `rd_en`=1, `rd_addr`=addr register.
  - Go to WAIT.
- **WAIT**
  - Load `rd_data` into a DBITS shift register.
  - Set byte counter to BYTES-1.
  - Increment addr modulo 2^ABITS (0xFF wraps to 0x00).
  - Decrement words-left.
  - Go to SHIFT.
- **SHIFT**
  - `tx_valid`=1, `tx_byte` = shift register [DBITS-1 -: 8].
  - On handshake: shift the register left by 8 and decrement the byte counter.
  - If the byte counter was 0 at the handshake:
    - words-left != 0: go to READ.
    - words-left == 0: go to IDLE and pulse `done`.
- `start` while `busy`: ignored; no latching, no effect on the transfer in progress.
- `tx_ready` high while `tx_valid` low: no effect.
- Reset value of every output is 0: `rd_en`, `rd_addr`, `tx_byte`, `tx_valid`, `busy`, `done`. State resets to IDLE; all internal registers reset to 0.
- Reset asserted mid-transfer: the block returns to IDLE immediately and asynchronously, and `tx_valid` drops. No `done` pulse is generated. The partial byte stream is abandoned.

## Timing
- `start` sampled in cycle 0:
  - `rd_en` high in cycle 1.
  - Data captured in cycle 2.
  - `tx_valid` high from cycle 3.
- `tx_byte` stays stable while `tx_valid && !tx_ready`. `tx_valid` never drops without a handshake, except on reset.
- With `tx_ready` held high, consecutive bytes of one word go out on consecutive cycles.
- Between words: last-byte handshake in cycle k, then READ in k+1, WAIT in k+2, next `tx_valid` in k+3. The gap is 2 cycles.
- Last byte of the last word handshaken in cycle k: `done`=1 and `busy`=0 in cycle k+1. A new `start` is accepted in cycle k+1.
- `word_count`=0 with `start` in cycle 0: `done`=1 in cycle 1; `busy` never rises.
- All outputs are registered; no combinational path from `tx_ready` to `tx_valid` or `tx_byte`.

## Structure
- Shared package holds:
  - State encoding (IDLE/READ/WAIT/SHIFT, 2 bits).
  - Host-link byte-order constant (MSB first), shared with the deserializer.
  - Default DBITS/ABITS values.
- One natural sub-module: `byte_shifter`. It is a DBITS load/shift-left-8 register with a byte counter and `last` flag, and owns load, shift-on-handshake and `tx_byte`. The FSM and address/word counters stay in the top.

## Test plan
- RAM[0x00]=0xDEADBEEF, start addr 0x00 count 1, `tx_ready`=1 -> `tx_byte` DE,AD,BE,EF on cycles 3..6; `done` on cycle 7; exactly one `rd_en`.
- RAM[0xFF]=0x01020304, RAM[0x00]=0xA0B0C0D0, start addr 0xFF count 2 -> `rd_addr` 0xFF then 0x00 (wrap); bytes 01 02 03 04 A0 B0 C0 D0 with a 2-cycle gap between words.
- Single word 0x11223344 with `tx_ready` low for 5 cycles at each byte -> `tx_byte` held stable each stall, `tx_valid` never drops, order 11 22 33 44.
- `start` with count 0 -> `done` high exactly cycle 1, `rd_en` never asserted, `busy` stays 0.
- Second `start` (addr 0x40, count 3) pulsed mid-transfer of a 1-word command -> ignored; exactly 4 bytes and one `done`.
- Reset asserted during the 2nd byte of a 2-word command -> all outputs 0 asynchronously, no `done`. A fresh 1-word command then completes normally.
